// File: rtl/cpuex_io_pkg.sv
// Shared types for the UART responder block.
// State encoding and rors meaning used by the FSM.
package cpuex_io_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        SEND,
        DONE
    } io_state_t;

    localparam logic RORS_RECV = 1'b0;
    localparam logic RORS_SEND = 1'b1;

endpackage

// File: rtl/io_sync_fifo.sv
// Synchronous FIFO with a registered occupancy count.
// The head entry is shown on dout, so a pop needs no extra read cycle.
module io_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] level_q, level_d;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (level_q == CNT_W'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign dout  = mem_q[rd_ptr_q];

    // A pop frees the slot that a same-cycle push lands in when full.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        unique case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + CNT_W'(1);
            2'b01:   level_d = level_q - CNT_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_io_unit.sv
// Responder side of the controller UART handshake.
// Serves buffered RX bytes to receives and hands send bytes to the TX PHY.
module uart_io_unit
    import cpuex_io_pkg::*;
#(
    parameter int RX_DEPTH = 16,
    parameter int CNT_W    = $clog2(RX_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             uart_go,
    input  logic             rors,
    input  logic [7:0]       wdata,
    output logic [31:0]      rdata,
    output logic             uart_done,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [7:0]       tx_data,
    output logic             rx_overrun,
    output logic [CNT_W-1:0] rx_level
);

    io_state_t  state_q, state_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic [7:0] rdata_q, rdata_d;
    logic       overrun_q, overrun_d;
    logic       pop;
    logic       tx_load;
    logic [7:0] fifo_head;
    logic       fifo_full;
    logic       fifo_empty;

    io_sync_fifo #(
        .WIDTH (8),
        .DEPTH (RX_DEPTH),
        .CNT_W (CNT_W)
    ) u_rx_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (rx_valid),
        .pop   (pop),
        .din   (rx_data),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (rx_level)
    );

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        tx_load = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (uart_go) begin
                    if (rors == RORS_SEND) begin
                        tx_load = 1'b1;
                        state_d = SEND;
                    end else begin
                        state_d = RECV;
                    end
                end
            end
            RECV: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = DONE;
                end
            end
            SEND: begin
                if (tx_ready) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign tx_data_d = tx_load ? wdata : tx_data_q;
    assign rdata_d   = pop ? fifo_head : rdata_q;
    // A byte is lost only when full and no pop makes room this cycle.
    assign overrun_d = overrun_q | (rx_valid & fifo_full & ~pop);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            tx_data_q <= '0;
            rdata_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            rdata_q   <= rdata_d;
            overrun_q <= overrun_d;
        end
    end

    assign rdata      = {24'b0, rdata_q};
    assign uart_done  = (state_q == DONE);
    assign tx_valid   = (state_q == SEND);
    assign tx_data    = tx_data_q;
    assign rx_overrun = overrun_q;

endmodule

// File: tb/tb_uart_io_unit.sv
// Directed bench for uart_io_unit with a 16-entry RX FIFO.
module tb_uart_io_unit;

    logic        clk;
    logic        rstn;
    logic        uart_go;
    logic        rors;
    logic [7:0]  wdata;
    logic [31:0] rdata;
    logic        uart_done;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        rx_overrun;
    logic [4:0]  rx_level;

    int checks   = 0;
    int failures = 0;

    uart_io_unit #(.RX_DEPTH(16)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .uart_go    (uart_go),
        .rors       (rors),
        .wdata      (wdata),
        .rdata      (rdata),
        .uart_done  (uart_done),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .rx_overrun (rx_overrun),
        .rx_level   (rx_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        tick();
    endtask

    // Receive with data buffered: done expected two cycles after go.
    task automatic recv_expect(input string tag, input logic [7:0] exp);
        int n;
        uart_go = 1'b1;
        rors    = 1'b0;
        for (n = 1; n <= 20; n++) begin
            tick();
            if (uart_done) break;
        end
        check({tag, "_lat"}, n, 2);
        check({tag, "_rdata"}, rdata, {24'b0, exp});
        uart_go = 1'b0;
        tick();
    endtask

    initial begin
        rstn     = 1'b0;
        uart_go  = 1'b0;
        rors     = 1'b0;
        wdata    = 8'h00;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b0;
        #3;
        check("rst_level", rx_level, 0);
        check("rst_rdata", rdata, 0);
        check("rst_txd", tx_data, 0);
        check("rst_txv", tx_valid, 0);
        check("rst_done", uart_done, 0);
        check("rst_ovr", rx_overrun, 0);
        do_reset();

        // Two buffered bytes, two receives
        push_byte(8'h41);
        push_byte(8'h42);
        check("t1_level2", rx_level, 2);
        uart_go = 1'b1;
        rors    = 1'b0;
        tick();
        check("t1_done_t1", uart_done, 0);
        tick();
        check("t1_done_t2", uart_done, 1);
        check("t1_rdata", rdata, 32'h41);
        check("t1_level1", rx_level, 1);
        uart_go = 1'b0;
        tick();
        check("t1_done_off", uart_done, 0);
        recv_expect("t1_b", 8'h42);
        check("t1_level0", rx_level, 0);

        // Receive waiting on an empty FIFO
        uart_go = 1'b1;
        rors    = 1'b0;
        repeat (5) begin
            tick();
            check("t2_wait", uart_done, 0);
        end
        push_byte(8'h7F);
        check("t2_done_p1", uart_done, 0);
        tick();
        check("t2_done_p2", uart_done, 1);
        check("t2_rdata", rdata, 32'h7F);
        uart_go = 1'b0;
        tick();

        // Send with backpressure
        wdata   = 8'hA5;
        rors    = 1'b1;
        uart_go = 1'b1;
        tick();
        wdata = 8'h00;
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) tx_ready = 1'b1;
            check("t3_txv", tx_valid, 1);
            check("t3_txd", tx_data, 8'hA5);
            check("t3_nodone", uart_done, 0);
            if (c < 4) tick();
        end
        tick();
        check("t3_done", uart_done, 1);
        check("t3_txv_drop", tx_valid, 0);
        check("t3_rdata", rdata, 32'h7F);
        uart_go  = 1'b0;
        tx_ready = 1'b0;
        tick();
        check("t3_idle", uart_done, 0);

        // Overflow: 17 pushes, byte 17 lost
        for (int i = 1; i <= 17; i++) push_byte(8'(i));
        check("t4_level", rx_level, 16);
        check("t4_ovr", rx_overrun, 1);
        for (int i = 1; i <= 16; i++) recv_expect("t4_rx", 8'(i));
        check("t4_empty", rx_level, 0);
        check("t4_ovr_sticky", rx_overrun, 1);

        // Full FIFO, push and pop in the same cycle
        do_reset();
        check("t5_ovr_clr", rx_overrun, 0);
        for (int i = 0; i < 16; i++) push_byte(8'h10 + 8'(i));
        check("t5_full", rx_level, 16);
        uart_go = 1'b1;
        rors    = 1'b0;
        tick();
        rx_valid = 1'b1;
        rx_data  = 8'hEE;
        tick();
        rx_valid = 1'b0;
        check("t5_done", uart_done, 1);
        check("t5_rdata", rdata, 32'h10);
        check("t5_level", rx_level, 16);
        check("t5_ovr", rx_overrun, 0);
        uart_go = 1'b0;
        tick();
        for (int i = 1; i < 16; i++) recv_expect("t5_rx", 8'h10 + 8'(i));
        recv_expect("t5_last", 8'hEE);
        check("t5_empty", rx_level, 0);

        // Reset in the middle of a send
        for (int i = 0; i < 17; i++) push_byte(8'h80);
        check("t6_ovr_pre", rx_overrun, 1);
        wdata    = 8'h33;
        rors     = 1'b1;
        uart_go  = 1'b1;
        tx_ready = 1'b0;
        tick();
        check("t6_txv_pre", tx_valid, 1);
        #2;
        rstn = 1'b0;
        #1;
        check("t6_txv", tx_valid, 0);
        check("t6_done", uart_done, 0);
        check("t6_level", rx_level, 0);
        check("t6_ovr", rx_overrun, 0);
        check("t6_txd", tx_data, 0);
        uart_go = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        tick();
        check("t6_post_done", uart_done, 0);
        check("t6_post_txv", tx_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_io_unit.md
Name: uart_io_unit

Overview:
- Responder end of the controller's UART handshake (uart_go / rors / uart_done).
- Buffers bytes from the UART receiver in an RX FIFO and serves them to receive instructions.
- Hands bytes from send instructions to the UART transmitter over a valid/ready link.
- Sits between the core controller/datapath and the serial rx/tx PHY blocks.

Parameters:
- RX_DEPTH, 16: RX FIFO entries; power of two, at least 2.
- CNT_W, $clog2(RX_DEPTH)+1: width of the FIFO occupancy counter.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- uart_go  in  1  request from controller; held high until uart_done is seen
- rors  in  1  0 = receive, 1 = send; valid while uart_go is high
- wdata  in  8  byte to send (register low byte); valid with uart_go & rors
- rdata  out  32  last received byte, zero-extended
- uart_done  out  1  one-cycle completion pulse to controller
- rx_valid  in  1  one-cycle strobe from UART receiver
- rx_data  in  8  received byte, valid with rx_valid
- tx_valid  out  1  byte available to transmitter
- tx_ready  in  1  transmitter can accept
- tx_data  out  8  byte to transmitter
- rx_overrun  out  1  sticky: a byte was dropped because the FIFO was full
- rx_level  out  CNT_W  current FIFO occupancy

Behaviour:
- Reset (async, rstn=0):
  - state IDLE; FIFO empty; rx_level 0; rdata 0; tx_data 0.
  - tx_valid 0, uart_done 0, rx_overrun 0.
  - Reset mid-transaction abandons it: no uart_done, no tx handoff, FIFO contents lost.
- FSM states: IDLE, RECV, SEND, DONE. uart_done=1 only in DONE (Moore output).
- IDLE:
  - uart_go & ~rors -> RECV.
  - uart_go & rors -> latch wdata into tx_data -> SEND.
  - Otherwise stay.
- RECV:
  - If rx_level>0 at cycle start: pop head, rdata <= {24'b0, head}, -> DONE.
  - Else stay; waits indefinitely for data.
- SEND:
  - tx_valid=1 with tx_data stable.
  - On tx_valid & tx_ready -> DONE. tx_valid drops the following cycle.
- DONE: one cycle, then -> IDLE unconditionally. uart_go is ignored in DONE.
  - Controller must drop uart_go in the cycle it sees uart_done.
  - A go seen in IDLE afterwards starts a new transaction.
- Latency:
  - Receive with data already buffered: go sampled cycle t, pop at t+1, uart_done at t+2; rdata valid from t+2.
  - Send with tx_ready=1: go at t, handoff at t+1, uart_done at t+2.
- rdata holds its value until the next completed receive; a send does not change it.
- RX FIFO:
  - Push on rx_valid if not full, or if a pop occurs in the same cycle.
  - Pop on an empty FIFO is impossible; no bypass. A byte arriving in the same cycle as RECV sees empty is popped the next cycle.
  - Full & rx_valid & no pop: byte dropped, rx_overrun <= 1 (cleared only by reset).
  - Simultaneous push and pop leaves rx_level unchanged.
  - Pointers wrap modulo RX_DEPTH.
  - rx_level ranges 0..RX_DEPTH.
- rx_valid is accepted in every state, including during a send.

Decomposition:
- cpuex_io_pkg:
  - io_state_t enum {IDLE, RECV, SEND, DONE}.
  - Constants RORS_RECV=1'b0, RORS_SEND=1'b1.
- Sub-module io_sync_fifo (parameters WIDTH, DEPTH):
  - Ports: push, pop, din, dout (head), full, empty, level.
  - Same clk/rstn.
- uart_io_unit holds the FSM, tx register, rdata register and overrun flag.

Test Plan:
- Reset, then push rx bytes 0x41 and 0x42; go with rors=0 -> uart_done at t+2, rdata=0x00000041, rx_level 2->1; second receive -> rdata=0x42, rx_level=0.
- Receive with FIFO empty; rx_valid 0x7F arrives 5 cycles later -> uart_done exactly 2 cycles after the push cycle, rdata=0x7F.
- Send wdata=0xA5 with tx_ready low 3 cycles then high -> tx_valid held 4 cycles, tx_data=0xA5 throughout, uart_done the cycle after handoff, rdata unchanged.
- Push 17 bytes with RX_DEPTH=16 -> rx_level=16, rx_overrun=1, byte 17 lost; 16 receives return bytes 1..16 in order.
- FIFO full, RECV pop in the same cycle as rx_valid -> no overrun, rx_level stays 16, new byte returned last.
- Assert rstn=0 while in SEND with tx_ready=0 -> tx_valid=0 immediately, no uart_done, rx_level=0, rx_overrun=0.
